// File: rtl/snake_body_engine.sv
// snake_body_engine: segment shift chain with variable length, heading lockout,
// wall/self collision and a valid/ready segment scan port for the draw FSM.
// Optional build macro: SNAKE_WRAP_EN (head wraps at screen edges, no wall hits).
module snake_body_engine #(
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned INIT_LEN = 4,
   parameter int unsigned SEG      = 10,
   parameter int unsigned XSCREEN  = 160,
   parameter int unsigned YSCREEN  = 120,
   parameter int unsigned X0       = 79,
   parameter int unsigned Y0       = 59
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic                           init,
   input  logic                           step,
   input  logic [1:0]                     dir,
   input  logic                           grow,
   input  logic                           rd_start,
   input  logic                           seg_ready,
   output logic                           seg_valid,
   output logic [7:0]                     seg_x,
   output logic [6:0]                     seg_y,
   output logic                           seg_last,
   output logic                           busy,
   output logic                           step_done,
   output logic [$clog2(MAX_LEN+1)-1:0]   length,
   output logic [7:0]                     head_x,
   output logic [6:0]                     head_y,
   output logic                           hit_wall,
   output logic                           hit_self
);

   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = $clog2(MAX_LEN);

   localparam logic [1:0] H_RIGHT = 2'b00;
   localparam logic [1:0] H_DOWN  = 2'b01;
   localparam logic [1:0] H_UP    = 2'b10;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SCAN = 1'b1;

   localparam logic [LW-1:0]        LEN_MAX = LW'(MAX_LEN);
   localparam logic signed [XW+1:0] SEG_X   = (XW+2)'(SEG);
   localparam logic signed [YW+1:0] SEG_Y   = (YW+2)'(SEG);
   localparam logic signed [XW+1:0] XMAX_S  = (XW+2)'(XSCREEN - SEG);
   localparam logic signed [YW+1:0] YMAX_S  = (YW+2)'(YSCREEN - SEG);

   logic [XW-1:0] slot_x   [MAX_LEN];
   logic [YW-1:0] slot_y   [MAX_LEN];
   logic [XW-1:0] slot_x_d [MAX_LEN];
   logic [YW-1:0] slot_y_d [MAX_LEN];

   logic [0:0]    state, state_d;
   logic [IW-1:0] index, index_d, idx_nx;
   logic [1:0]    heading, heading_d, hd_new;
   logic          grow_pend, grow_pend_d, step_pend, step_pend_d, grow_eff;
   logic          seg_valid_d, seg_last_d, busy_d, step_done_d;
   logic          hit_wall_d, hit_self_d, alive;
   logic [XW-1:0] seg_x_d, nhx;
   logic [YW-1:0] seg_y_d, nhy;
   logic [LW-1:0] length_d;

   logic signed [XW+1:0] hx_s, nx;
   logic signed [YW+1:0] hy_s, ny;
   logic                 wall, self_hit;
   int                   self_hi;

   assign head_x = slot_x[0];
   assign head_y = slot_y[0];

   // Candidate head position for the next step, plus wall and self collision tests
   always_comb begin
      hd_new   = (dir == ~heading) ? heading : dir;
      grow_eff = grow_pend | grow;
      hx_s     = $signed({2'b00, slot_x[0]});
      hy_s     = $signed({2'b00, slot_y[0]});
      nx       = hx_s;
      ny       = hy_s;
      case (hd_new)
         H_RIGHT: nx = hx_s + SEG_X;
         H_DOWN:  ny = hy_s + SEG_Y;
         H_UP:    ny = hy_s - SEG_Y;
         default: nx = hx_s - SEG_X;
      endcase
`ifdef SNAKE_WRAP_EN
      wall = 1'b0;
      if (nx[XW+1])       nhx = XW'(XSCREEN - SEG);
      else if (nx > XMAX_S) nhx = '0;
      else                nhx = nx[XW-1:0];
      if (ny[YW+1])       nhy = YW'(YSCREEN - SEG);
      else if (ny > YMAX_S) nhy = '0;
      else                nhy = ny[YW-1:0];
`else
      wall = nx[XW+1] || (nx > XMAX_S) || ny[YW+1] || (ny > YMAX_S);
      nhx  = nx[XW-1:0];
      nhy  = ny[YW-1:0];
`endif
      // A growing snake keeps its tail, so the tail slot becomes a hazard too
      self_hi  = int'(length) - ((grow_eff && (length < LEN_MAX)) ? 1 : 2);
      self_hit = 1'b0;
      for (int k = 1; k < int'(MAX_LEN); k++) begin
         if ((k <= self_hi) && (slot_x[k] == nhx) && (slot_y[k] == nhy))
            self_hit = 1'b1;
      end
   end

   // Next-state logic: init, step application, step pending and scan sequencing
   always_comb begin
      slot_x_d    = slot_x;
      slot_y_d    = slot_y;
      state_d     = state;
      index_d     = index;
      heading_d   = heading;
      grow_pend_d = grow_pend | grow;
      step_pend_d = step_pend;
      seg_valid_d = seg_valid;
      seg_last_d  = seg_last;
      seg_x_d     = seg_x;
      seg_y_d     = seg_y;
      busy_d      = busy;
      step_done_d = 1'b0;
      length_d    = length;
      hit_wall_d  = hit_wall;
      hit_self_d  = hit_self;
      alive       = !(hit_wall || hit_self) && (length != '0);
      idx_nx      = index + IW'(1);

      if (init) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            slot_x_d[i] = (i < int'(INIT_LEN)) ? XW'(X0 - i * SEG) : '0;
            slot_y_d[i] = (i < int'(INIT_LEN)) ? YW'(Y0) : '0;
         end
         length_d    = LW'(INIT_LEN);
         heading_d   = H_RIGHT;
         hit_wall_d  = 1'b0;
         hit_self_d  = 1'b0;
         grow_pend_d = 1'b0;
         step_pend_d = 1'b0;
         state_d     = S_IDLE;
         index_d     = '0;
         seg_valid_d = 1'b0;
         seg_last_d  = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (alive && (step || step_pend)) begin
                  step_pend_d = 1'b0;
                  step_done_d = 1'b1;
                  heading_d   = hd_new;
                  if (wall) begin
                     hit_wall_d = 1'b1;
                  end else begin
                     for (int i = 1; i < int'(MAX_LEN); i++) begin
                        slot_x_d[i] = slot_x[i-1];
                        slot_y_d[i] = slot_y[i-1];
                     end
                     slot_x_d[0] = nhx;
                     slot_y_d[0] = nhy;
                     if (self_hit) hit_self_d = 1'b1;
                     if (grow_eff) begin
                        grow_pend_d = 1'b0;
                        if (length < LEN_MAX) length_d = length + LW'(1);
                     end
                  end
               end else begin
                  step_pend_d = 1'b0;
                  if (rd_start && !step && !step_pend && (length != '0)) begin
                     state_d     = S_SCAN;
                     index_d     = '0;
                     seg_valid_d = 1'b1;
                     busy_d      = 1'b1;
                     seg_x_d     = slot_x[0];
                     seg_y_d     = slot_y[0];
                     seg_last_d  = (length == LW'(1));
                  end
               end
            end
            default: begin
               if (step && alive) step_pend_d = 1'b1;
               if (seg_ready) begin
                  if (seg_last) begin
                     state_d     = S_IDLE;
                     seg_valid_d = 1'b0;
                     seg_last_d  = 1'b0;
                     busy_d      = 1'b0;
                  end else begin
                     index_d    = idx_nx;
                     seg_x_d    = slot_x[idx_nx];
                     seg_y_d    = slot_y[idx_nx];
                     seg_last_d = (LW'(idx_nx) == (length - LW'(1)));
                  end
               end
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            slot_x[i] <= '0;
            slot_y[i] <= '0;
         end
         state     <= S_IDLE;
         index     <= '0;
         heading   <= H_RIGHT;
         grow_pend <= 1'b0;
         step_pend <= 1'b0;
         seg_valid <= 1'b0;
         seg_last  <= 1'b0;
         seg_x     <= '0;
         seg_y     <= '0;
         busy      <= 1'b0;
         step_done <= 1'b0;
         length    <= '0;
         hit_wall  <= 1'b0;
         hit_self  <= 1'b0;
      end else begin
         slot_x    <= slot_x_d;
         slot_y    <= slot_y_d;
         state     <= state_d;
         index     <= index_d;
         heading   <= heading_d;
         grow_pend <= grow_pend_d;
         step_pend <= step_pend_d;
         seg_valid <= seg_valid_d;
         seg_last  <= seg_last_d;
         seg_x     <= seg_x_d;
         seg_y     <= seg_y_d;
         busy      <= busy_d;
         step_done <= step_done_d;
         length    <= length_d;
         hit_wall  <= hit_wall_d;
         hit_self  <= hit_self_d;
      end
   end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine; expectations follow SNAKE_WRAP_EN when defined.
module tb_snake_body_engine;

   logic       Clock = 1'b0;
   logic       Reset, init, step, grow, rd_start, seg_ready;
   logic [1:0] dir;
   logic       seg_valid, seg_last, busy, step_done, hit_wall, hit_self;
   logic [7:0] seg_x, head_x;
   logic [6:0] seg_y, head_y;
   logic [4:0] length;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_x [16];
   logic [6:0] exp_y [16];

   snake_body_engine dut (
      .Clock(Clock), .Reset(Reset), .init(init), .step(step), .dir(dir),
      .grow(grow), .rd_start(rd_start), .seg_ready(seg_ready),
      .seg_valid(seg_valid), .seg_x(seg_x), .seg_y(seg_y), .seg_last(seg_last),
      .busy(busy), .step_done(step_done), .length(length),
      .head_x(head_x), .head_y(head_y), .hit_wall(hit_wall), .hit_self(hit_self)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(negedge Clock);
   endtask

   task automatic do_step(input logic [1:0] d);
      dir = d; step = 1'b1; cyc(); step = 1'b0;
   endtask

   task automatic pulse_init;
      init = 1'b1; cyc(); init = 1'b0;
   endtask

   task automatic pulse_grow;
      grow = 1'b1; cyc(); grow = 1'b0;
   endtask

   // Full scan with the drawer always ready; compares against exp_x/exp_y
   task automatic scan_check(input string tag, input int n);
      rd_start = 1'b1; seg_ready = 1'b1; cyc(); rd_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, seg_valid, 1);
         check({tag, "_x"}, seg_x, exp_x[i]);
         check({tag, "_y"}, seg_y, exp_y[i]);
         check({tag, "_last"}, seg_last, (i == n - 1));
         cyc();
      end
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_valid_end"}, seg_valid, 0);
      seg_ready = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; init = 1'b0; step = 1'b0; grow = 1'b0;
      rd_start = 1'b0; seg_ready = 1'b0; dir = 2'b00;
      cyc(); cyc();
      Reset = 1'b0;

      // Reset state
      check("rst_len", length, 0);
      check("rst_valid", seg_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_hx", head_x, 0);
      check("rst_done", step_done, 0);
      check("rst_wall", hit_wall, 0);
      check("rst_self", hit_self, 0);

      // Init and scan of the initial snake
      pulse_init();
      check("init_len", length, 4);
      check("init_hx", head_x, 79);
      check("init_hy", head_y, 59);
      for (int i = 0; i < 4; i++) begin
         exp_x[i] = 8'(79 - 10 * i); exp_y[i] = 7'd59;
      end
      scan_check("scan0", 4);

      // Plain step right, then reversal lockout
      do_step(2'b00);
      check("st1_done", step_done, 1);
      check("st1_hx", head_x, 89);
      check("st1_hy", head_y, 59);
      cyc();
      check("st1_done_off", step_done, 0);
      for (int i = 0; i < 4; i++) begin
         exp_x[i] = 8'(89 - 10 * i); exp_y[i] = 7'd59;
      end
      scan_check("scan1", 4);
      do_step(2'b11);
      check("rev_hx", head_x, 99);
      check("rev_hy", head_y, 59);

      // Growth up to MAX_LEN along an L-shaped path
      pulse_init();
      pulse_grow();
      do_step(2'b00);
      check("gr_len5", length, 5);
      for (int i = 0; i < 5; i++) begin
         exp_x[i] = 8'(89 - 10 * i); exp_y[i] = 7'd59;
      end
      scan_check("scan_gr", 5);
      for (int k = 0; k < 12; k++) begin
         pulse_grow();
         do_step((k < 5) ? 2'b01 : 2'b11);
         check("gr_len", length, (6 + k > 16) ? 16 : 6 + k);
      end
      check("gr_hx", head_x, 19);
      check("gr_hy", head_y, 109);
      check("gr_self", hit_self, 0);
      check("gr_wall", hit_wall, 0);

      // Top wall
      pulse_init();
      for (int k = 0; k < 5; k++) do_step(2'b10);
      check("up5_hx", head_x, 79);
      check("up5_hy", head_y, 9);
      do_step(2'b10);
      check("up6_done", step_done, 1);
`ifdef SNAKE_WRAP_EN
      check("up6_hy", head_y, 110);
      check("up6_wall", hit_wall, 0);
      do_step(2'b10);
      check("up7_done", step_done, 1);
      check("up7_hy", head_y, 100);
`else
      check("up6_hy", head_y, 9);
      check("up6_wall", hit_wall, 1);
      do_step(2'b10);
      check("up7_done", step_done, 0);
      check("up7_hy", head_y, 9);
`endif
      pulse_init();
      check("reinit_wall", hit_wall, 0);
      check("reinit_hy", head_y, 59);

      // Step raised during a stalled scan is deferred until the scan ends
      rd_start = 1'b1; seg_ready = 1'b0; cyc(); rd_start = 1'b0;
      check("ms_busy", busy, 1);
      check("ms_x0", seg_x, 79);
      do_step(2'b01);
      check("ms_hold_x", seg_x, 79);
      check("ms_hold_v", seg_valid, 1);
      check("ms_hold_hy", head_y, 59);
      check("ms_hold_done", step_done, 0);
      cyc();
      check("ms_stall_x", seg_x, 79);
      seg_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         cyc();
         check("ms_x", seg_x, 8'(79 - 10 * i));
         check("ms_y", seg_y, 59);
      end
      check("ms_last", seg_last, 1);
      cyc();
      seg_ready = 1'b0;
      check("ms_busy_end", busy, 0);
      check("ms_pre_hy", head_y, 59);
      check("ms_pre_done", step_done, 0);
      cyc();
      check("ms_post_hy", head_y, 69);
      check("ms_post_hx", head_x, 79);
      check("ms_post_done", step_done, 1);

      // Self collision after growing to length 5
      pulse_init();
      pulse_grow();
      do_step(2'b00);
      do_step(2'b01);
      do_step(2'b11);
      check("sf_pre", hit_self, 0);
      do_step(2'b10);
      check("sf_hit", hit_self, 1);
      check("sf_hx", head_x, 79);
      check("sf_hy", head_y, 59);
      check("sf_len", length, 5);

      // Reset during a scan
      pulse_init();
      check("rs_self_clr", hit_self, 0);
      rd_start = 1'b1; cyc(); rd_start = 1'b0;
      check("rs_busy", busy, 1);
      Reset = 1'b1; cyc(); Reset = 1'b0;
      check("rs_valid", seg_valid, 0);
      check("rs_len", length, 0);
      check("rs_busy_off", busy, 0);
      do_step(2'b00);
      check("rs_step_ign", step_done, 0);
      check("rs_hx", head_x, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
